// File: rtl/control_seq_pkg.sv
// control_seq_pkg
//   Shared constants for the multicycle control sequencer and the datapath
//   blocks that decode its outputs.
//   - CTRL_W / BIT_*  : width and bit positions of the one-hot control vector
//   - pc_op_e         : PC operation select driven to pc_unit
//   - ctrl_bit()      : helper returning a one-hot control word for a bit index
package control_seq_pkg;

    localparam int CTRL_W       = 8;
    localparam int BIT_FETCH    = 0;
    localparam int BIT_DECODE   = 1;
    localparam int BIT_REG_READ = 2;
    localparam int BIT_ALU      = 3;
    localparam int BIT_MEM      = 4;
    localparam int BIT_REG_WR   = 5;
    localparam int BIT_PC_DELAY = 6;
    localparam int BIT_IRQ_SAVE = 7;

    typedef enum logic [2:0] {
        PC_NOP   = 3'd0,
        PC_INC   = 3'd1,
        PC_SET   = 3'd2,
        PC_RESET = 3'd3,
        PC_VEC   = 3'd4
    } pc_op_e;

    function automatic logic [CTRL_W-1:0] ctrl_bit(input int idx);
        logic [CTRL_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/control_seq_irq_prio_enc.sv
// irq_prio_enc
//   Lowest-index-wins priority encoder for the interrupt request lines.
//   Ports:
//     i_req    [N-1:0]    request vector
//     o_valid             any request set
//     o_id     [ID_W-1:0] index of the lowest set request (0 when none)
//     o_onehot [N-1:0]    one-hot of the winning request (0 when none)
module irq_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 4
) (
    input  logic [N-1:0]    i_req,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id,
    output logic [N-1:0]    o_onehot
);

    always_comb begin
        o_valid  = |i_req;
        o_id     = '0;
        o_onehot = '0;
        // Scan from the top down so the last hit, the lowest index, wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id        = ID_W'(i);
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_seq.sv
// control_seq
//   Multicycle control sequencer: fetch, decode, register read, ALU, memory
//   and register write, with fetch wait states, memory bus timeout trap,
//   prioritised interrupts with acknowledge, and a halt state.
//   Ports:
//     i_clk, i_rst_n       clock, synchronous active-low reset
//     i_en                 advance enable; low freezes state, counter, irq id
//     i_ifetch_wait        instruction memory not ready
//     i_en_mem             current instruction accesses memory
//     i_mem_wait           data memory not ready
//     i_should_branch      branch taken
//     i_imm                instruction carries an immediate word
//     i_irq [IRQ_LINES]    level-sensitive interrupt requests
//     i_irq_en             global interrupt enable
//     i_halt_req           halt request
//     o_control [CTRL_W]   one-hot control strobes
//     o_pc_op [3]          PC operation select
//     o_irq_ack [IRQ_LINES] one-cycle one-hot acknowledge
//     o_irq_id [IRQ_ID_W]  latched vector id; IRQ_LINES means bus trap
//     o_bus_err            one-cycle pulse when the memory timeout fires
//     o_halted             high while halted
//     o_state [4]          current state, for debug/observation:
//                          0 RST 1 FETCH 2 DECODE 3 REG_READ 4 ALU 5 MEM
//                          6 MEM_DELAY 7 REG_WR 8 PC_DELAY 9 TRAP
//                          10 IRQ_SAVE 11 IRQ_VEC 12 HALT
//   IRQ_ID_W must satisfy 2**IRQ_ID_W > IRQ_LINES so the trap id fits.
module control_seq
    import control_seq_pkg::*;
#(
    parameter int IRQ_LINES   = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int IRQ_ID_W    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_ifetch_wait,
    input  logic                 i_en_mem,
    input  logic                 i_mem_wait,
    input  logic                 i_should_branch,
    input  logic                 i_imm,
    input  logic [IRQ_LINES-1:0] i_irq,
    input  logic                 i_irq_en,
    input  logic                 i_halt_req,
    output logic [CTRL_W-1:0]    o_control,
    output logic [2:0]           o_pc_op,
    output logic [IRQ_LINES-1:0] o_irq_ack,
    output logic [IRQ_ID_W-1:0]  o_irq_id,
    output logic                 o_bus_err,
    output logic                 o_halted,
    output logic [3:0]           o_state
);

    typedef enum logic [3:0] {
        S_RST       = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_REG_READ  = 4'd3,
        S_ALU       = 4'd4,
        S_MEM       = 4'd5,
        S_MEM_DELAY = 4'd6,
        S_REG_WR    = 4'd7,
        S_PC_DELAY  = 4'd8,
        S_TRAP      = 4'd9,
        S_IRQ_SAVE  = 4'd10,
        S_IRQ_VEC   = 4'd11,
        S_HALT      = 4'd12
    } state_e;

    localparam int CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IRQ_ID_W-1:0] r_irq_id;
    logic                r_trap;    // IRQ_SAVE was entered from TRAP

    logic                 w_irq_pend;
    logic                 w_irq_valid;
    logic [IRQ_ID_W-1:0]  w_irq_id;
    logic [IRQ_LINES-1:0] w_irq_onehot;
    logic                 w_timeout;

    irq_prio_enc #(
        .N    (IRQ_LINES),
        .ID_W (IRQ_ID_W)
    ) u_prio (
        .i_req    (i_irq),
        .o_valid  (w_irq_valid),
        .o_id     (w_irq_id),
        .o_onehot (w_irq_onehot)
    );

    assign w_irq_pend = i_irq_en & (|i_irq);
    // Counter sits at MEM_TIMEOUT-1 on the last permitted wait cycle.
    assign w_timeout  = (MEM_TIMEOUT > 0) && (r_cnt == CNT_W'(TO_LAST));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_RST;
            r_cnt    <= '0;
            r_irq_id <= '0;
            r_trap   <= 1'b0;
        end else if (i_en) begin
            case (r_state)
                S_RST:    r_state <= S_FETCH;
                S_FETCH:  if (!i_ifetch_wait) r_state <= S_DECODE;
                S_DECODE: r_state <= S_REG_READ;
                S_REG_READ: r_state <= S_ALU;
                S_ALU: begin
                    r_cnt <= '0;
                    r_state <= i_en_mem ? S_MEM : S_REG_WR;
                end
                S_MEM: begin
                    // A released mem_wait beats the timeout on the same cycle.
                    if (!i_mem_wait) begin
                        r_cnt   <= '0;
                        r_state <= S_MEM_DELAY;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_MEM_DELAY: r_state <= S_REG_WR;
                S_REG_WR: begin
                    if (i_should_branch)  r_state <= S_PC_DELAY;
                    else if (w_irq_pend)  r_state <= S_IRQ_SAVE;
                    else if (i_halt_req)  r_state <= S_HALT;
                    else                  r_state <= S_DECODE;
                end
                S_PC_DELAY: r_state <= w_irq_pend ? S_IRQ_SAVE : S_FETCH;
                S_TRAP: begin
                    r_irq_id <= IRQ_ID_W'(IRQ_LINES);
                    r_trap   <= 1'b1;
                    r_state  <= S_IRQ_SAVE;
                end
                S_IRQ_SAVE: begin
                    // A request that vanished keeps the previous id.
                    if (!r_trap && w_irq_valid) r_irq_id <= w_irq_id;
                    r_trap  <= 1'b0;
                    r_state <= S_IRQ_VEC;
                end
                S_IRQ_VEC: r_state <= S_FETCH;
                S_HALT: begin
                    if (w_irq_pend)       r_state <= S_IRQ_SAVE;
                    else if (!i_halt_req) r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        o_control = '0;
        o_pc_op   = PC_NOP;
        o_irq_ack = '0;
        o_bus_err = 1'b0;
        o_halted  = 1'b0;
        case (r_state)
            S_RST: o_pc_op = PC_RESET;
            S_FETCH: begin
                o_control = ctrl_bit(BIT_FETCH);
                o_pc_op   = i_ifetch_wait ? PC_NOP : PC_INC;
            end
            S_DECODE: o_control = ctrl_bit(BIT_DECODE);
            S_REG_READ: begin
                o_control = ctrl_bit(BIT_REG_READ);
                o_pc_op   = i_imm ? PC_INC : PC_NOP;
            end
            S_ALU: o_control = ctrl_bit(BIT_ALU);
            S_MEM: o_control = ctrl_bit(BIT_MEM);
            S_REG_WR: begin
                o_control = ctrl_bit(BIT_REG_WR);
                if (i_should_branch) begin
                    o_pc_op = PC_SET;
                end else if (!w_irq_pend && !i_halt_req) begin
                    // Overlapped fetch of the next instruction.
                    o_control = ctrl_bit(BIT_REG_WR) | ctrl_bit(BIT_FETCH);
                    o_pc_op   = PC_INC;
                end
            end
            S_PC_DELAY: o_control = ctrl_bit(BIT_PC_DELAY);
            S_TRAP: o_bus_err = i_en;
            S_IRQ_SAVE: begin
                o_control = ctrl_bit(BIT_IRQ_SAVE);
                if (!r_trap && i_en) o_irq_ack = w_irq_onehot;
            end
            S_IRQ_VEC: o_pc_op = PC_VEC;
            S_HALT: o_halted = 1'b1;
            default: ;
        endcase
    end

    assign o_irq_id = r_irq_id;
    assign o_state  = r_state;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq. Each step drives inputs just after a rising
// edge, pushes the expected output vector, and pops/compares it at the
// following falling edge.
module tb_control_seq;

    localparam int W = 25;

    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
        S_REG_READ = 4'd3, S_ALU = 4'd4, S_MEM = 4'd5, S_MEM_DELAY = 4'd6,
        S_REG_WR = 4'd7, S_PC_DELAY = 4'd8, S_TRAP = 4'd9, S_IRQ_SAVE = 4'd10,
        S_IRQ_VEC = 4'd11, S_HALT = 4'd12;

    localparam logic [7:0] C_F = 8'h01, C_D = 8'h02, C_RR = 8'h04, C_A = 8'h08,
        C_M = 8'h10, C_RW = 8'h20, C_PD = 8'h40, C_IS = 8'h80;

    localparam logic [2:0] P_NOP = 3'd0, P_INC = 3'd1, P_SET = 3'd2,
        P_RST = 3'd3, P_VEC = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n, en, ifetch_wait, en_mem, mem_wait, should_branch, imm;
    logic [3:0] irq;
    logic       irq_en, halt_req;
    logic [7:0] control;
    logic [2:0] pc_op;
    logic [3:0] irq_ack, irq_id, state;
    logic       bus_err, halted;

    logic [W-1:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    control_seq #(.IRQ_LINES(4), .MEM_TIMEOUT(16), .IRQ_ID_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_ifetch_wait(ifetch_wait),
        .i_en_mem(en_mem), .i_mem_wait(mem_wait),
        .i_should_branch(should_branch), .i_imm(imm), .i_irq(irq),
        .i_irq_en(irq_en), .i_halt_req(halt_req), .o_control(control),
        .o_pc_op(pc_op), .o_irq_ack(irq_ack), .o_irq_id(irq_id),
        .o_bus_err(bus_err), .o_halted(halted), .o_state(state)
    );

    // Push the expected vector, sample at the falling edge, then advance one
    // cycle and leave the bench 1 time unit past the rising edge.
    task automatic cyc(input string tag, input logic [3:0] st,
                       input logic [7:0] ctl, input logic [2:0] pc,
                       input logic [3:0] ack, input logic [3:0] id,
                       input logic be, input logic hl);
        logic [W-1:0] e;
        logic [W-1:0] o;
        exp_q.push_back({st, ctl, pc, ack, id, be, hl});
        @(negedge clk);
        e = exp_q.pop_front();
        o = {state, control, pc_op, irq_ack, irq_id, bus_err, halted};
        tests_run++;
        assert (o === e) else begin
            tests_failed++;
            $error("FAIL %s got st=%0d ctl=%h pc=%0d ack=%b id=%0d be=%b hl=%b want st=%0d ctl=%h pc=%0d ack=%b id=%0d be=%b hl=%b",
                   tag, o[24:21], o[20:13], o[12:10], o[9:6], o[5:2], o[1], o[0],
                   e[24:21], e[20:13], e[12:10], e[9:6], e[5:2], e[1], e[0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; ifetch_wait = 1'b0; en_mem = 1'b0;
        mem_wait = 1'b0; should_branch = 1'b0; imm = 1'b0; irq = 4'b0;
        irq_en = 1'b0; halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic instruction, no memory, no immediate, no branch.
        cyc("rst",      S_RST,      8'h00,      P_RST, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("fetch",    S_FETCH,    C_F,        P_INC, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("decode",   S_DECODE,   C_D,        P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("regrd",    S_REG_READ, C_RR,       P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("alu",      S_ALU,      C_A,        P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("regwr_ov", S_REG_WR,   C_RW | C_F, P_INC, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("decode2",  S_DECODE,   C_D,        P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);

        // Immediate, memory access with 5 wait cycles, then taken branch.
        imm = 1'b1;
        cyc("regrd_imm", S_REG_READ, C_RR, P_INC, 4'b0, 4'd0, 1'b0, 1'b0);
        imm = 1'b0; en_mem = 1'b1;
        cyc("alu_mem",   S_ALU,      C_A,  P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        en_mem = 1'b0; mem_wait = 1'b1;
        for (int i = 0; i < 5; i++)
            cyc("mem_wait5", S_MEM, C_M, P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        mem_wait = 1'b0;
        cyc("mem_done",  S_MEM,       C_M,   P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("mem_delay", S_MEM_DELAY, 8'h00, P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        should_branch = 1'b1;
        cyc("regwr_br",  S_REG_WR,    C_RW,  P_SET, 4'b0, 4'd0, 1'b0, 1'b0);
        should_branch = 1'b0;
        cyc("pc_delay",  S_PC_DELAY,  C_PD,  P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);

        // Fetch wait states.
        ifetch_wait = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc("fetch_wait", S_FETCH, C_F, P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        ifetch_wait = 1'b0;
        cyc("fetch_go", S_FETCH,    C_F,  P_INC, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("decode3",  S_DECODE,   C_D,  P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("regrd3",   S_REG_READ, C_RR, P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        en_mem = 1'b1;
        cyc("alu3",     S_ALU,      C_A,  P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        en_mem = 1'b0;

        // mem_wait released exactly on the timeout cycle: no trap.
        mem_wait = 1'b1;
        for (int i = 0; i < 15; i++)
            cyc("mem_nearto", S_MEM, C_M, P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        mem_wait = 1'b0;
        cyc("mem_edge",  S_MEM,       C_M,   P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("mem_dly2",  S_MEM_DELAY, 8'h00, P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("regwr2",    S_REG_WR,    C_RW | C_F, P_INC, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("decode4",   S_DECODE,    C_D,   P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("regrd4",    S_REG_READ,  C_RR,  P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        en_mem = 1'b1;
        cyc("alu4",      S_ALU,       C_A,   P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        en_mem = 1'b0;

        // mem_wait stuck: trap after 16 MEM cycles; en=0 in TRAP holds it
        // and suppresses bus_err.
        mem_wait = 1'b1;
        for (int i = 0; i < 16; i++)
            cyc("mem_stuck", S_MEM, C_M, P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        mem_wait = 1'b0; en = 1'b0;
        cyc("trap_hold", S_TRAP,     8'h00, P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        en = 1'b1;
        cyc("trap",      S_TRAP,     8'h00, P_NOP, 4'b0, 4'd0, 1'b1, 1'b0);
        cyc("save_trap", S_IRQ_SAVE, C_IS,  P_NOP, 4'b0, 4'd4, 1'b0, 1'b0);
        cyc("vec_trap",  S_IRQ_VEC,  8'h00, P_VEC, 4'b0, 4'd4, 1'b0, 1'b0);
        cyc("fetch5",    S_FETCH,    C_F,   P_INC, 4'b0, 4'd4, 1'b0, 1'b0);

        // Interrupt at REG_WR: lowest of 4'b0110 is line 1.
        cyc("decode5",   S_DECODE,   C_D,   P_NOP, 4'b0, 4'd4, 1'b0, 1'b0);
        cyc("regrd5",    S_REG_READ, C_RR,  P_NOP, 4'b0, 4'd4, 1'b0, 1'b0);
        cyc("alu5",      S_ALU,      C_A,   P_NOP, 4'b0, 4'd4, 1'b0, 1'b0);
        irq = 4'b0110; irq_en = 1'b1;
        cyc("regwr_irq", S_REG_WR,   C_RW,  P_NOP, 4'b0,    4'd4, 1'b0, 1'b0);
        cyc("save_irq",  S_IRQ_SAVE, C_IS,  P_NOP, 4'b0010, 4'd4, 1'b0, 1'b0);
        irq = 4'b0; irq_en = 1'b0;
        cyc("vec_irq",   S_IRQ_VEC,  8'h00, P_VEC, 4'b0,    4'd1, 1'b0, 1'b0);

        // Reset beats en=0 and clears irq_id.
        en = 1'b0; rst_n = 1'b0;
        cyc("fetch_rst", S_FETCH,    C_F,   P_INC, 4'b0, 4'd1, 1'b0, 1'b0);
        en = 1'b1; rst_n = 1'b1;
        cyc("rst2",      S_RST,      8'h00, P_RST, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("fetch6",    S_FETCH,    C_F,   P_INC, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("decode6",   S_DECODE,   C_D,   P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("regrd6",    S_REG_READ, C_RR,  P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("alu6",      S_ALU,      C_A,   P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);

        // Request present but globally masked: normal overlapped fetch.
        irq = 4'b0110; irq_en = 1'b0;
        cyc("regwr_msk", S_REG_WR,   C_RW | C_F, P_INC, 4'b0, 4'd0, 1'b0, 1'b0);
        irq = 4'b0;
        cyc("decode7",   S_DECODE,   C_D,   P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("regrd7",    S_REG_READ, C_RR,  P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("alu7",      S_ALU,      C_A,   P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);

        // Halt, then release.
        halt_req = 1'b1;
        cyc("regwr_hlt", S_REG_WR,   C_RW,  P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("halt1",     S_HALT,     8'h00, P_NOP, 4'b0, 4'd0, 1'b0, 1'b1);
        halt_req = 1'b0;
        cyc("halt2",     S_HALT,     8'h00, P_NOP, 4'b0, 4'd0, 1'b0, 1'b1);
        cyc("fetch8",    S_FETCH,    C_F,   P_INC, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("decode8",   S_DECODE,   C_D,   P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("regrd8",    S_REG_READ, C_RR,  P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("alu8",      S_ALU,      C_A,   P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);

        // Halt, then wake on irq[0] while halt_req is still high.
        halt_req = 1'b1; irq_en = 1'b1;
        cyc("regwr_h2",  S_REG_WR,   C_RW,  P_NOP, 4'b0, 4'd0, 1'b0, 1'b0);
        cyc("halt3",     S_HALT,     8'h00, P_NOP, 4'b0, 4'd0, 1'b0, 1'b1);
        irq = 4'b0001;
        cyc("halt_wake", S_HALT,     8'h00, P_NOP, 4'b0,    4'd0, 1'b0, 1'b1);
        cyc("save_wake", S_IRQ_SAVE, C_IS,  P_NOP, 4'b0001, 4'd0, 1'b0, 1'b0);
        irq = 4'b0; halt_req = 1'b0;
        cyc("vec_wake",  S_IRQ_VEC,  8'h00, P_VEC, 4'b0,    4'd0, 1'b0, 1'b0);
        cyc("fetch9",    S_FETCH,    C_F,   P_INC, 4'b0,    4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Parametrised successor to the d16 multicycle control FSM. It sequences fetch, decode, register read, ALU, memory and register write, and drives the one-hot control vector and the PC operation.
- Adds the following over the previous generation: instruction-fetch wait states, a memory bus timeout trap, N prioritised interrupt lines with acknowledge, and a halt state.
- Sits between the core datapath (pc_unit, alu, regfile, mem interface) and the interrupt/status logic.

Parameters:
- IRQ_LINES, 4, number of interrupt request inputs (1..15).
- MEM_TIMEOUT, 16, number of consecutive mem_wait cycles in MEM before a bus trap. 0 disables the timeout.
- IRQ_ID_W, 4, width of irq_id. Must satisfy 2^IRQ_ID_W > IRQ_LINES.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- en  in  1  global advance enable; when low, state and counters hold
- ifetch_wait  in  1  instruction memory not ready
- en_mem  in  1  current instruction accesses memory
- mem_wait  in  1  data memory not ready
- should_branch  in  1  branch taken, from the ALU flags
- imm  in  1  instruction carries an immediate word
- irq  in  IRQ_LINES  level-sensitive interrupt requests
- irq_en  in  1  global interrupt enable, from the status register
- halt_req  in  1  halt request (debug/sleep)
- control_o  out  CTRL_W  one-hot control strobes
- pc_op  out  3  PC operation select
- irq_ack  out  IRQ_LINES  one-cycle one-hot acknowledge
- irq_id  out  IRQ_ID_W  latched vector id; IRQ_LINES denotes bus trap
- bus_err  out  1  one-cycle pulse on timeout
- halted  out  1  high while in HALT

Behaviour:
- States: RST, FETCH, DECODE, REG_READ, ALU, MEM, MEM_DELAY, REG_WR, PC_DELAY, TRAP, IRQ_SAVE, IRQ_VEC, HALT.
- Reset (rst_n=0 at a clk edge), which takes priority over en:
  - state=RST, wait counter=0, irq_id=0.
  - Combinational outputs in RST: control_o=0, pc_op=PC_RESET, irq_ack=0, bus_err=0, halted=0.
- Outputs are combinational from state and inputs (Moore, plus the listed Mealy terms). Unlisted outputs in any state are 0 / PC_NOP.
- Interrupt pending: irq_pend = irq_en & |irq. Selection is by lowest index.
- Transitions and outputs:
  - RST -> FETCH.
  - FETCH:
    - BIT_FETCH is asserted.
    - If ifetch_wait: pc_op=NOP and stay in FETCH.
    - Else: pc_op=INC, go to DECODE.
  - DECODE: BIT_DECODE, go to REG_READ.
  - REG_READ: BIT_REG_READ; pc_op=INC if imm; go to ALU.
  - ALU: BIT_ALU; go to MEM if en_mem, else to REG_WR.
  - MEM:
    - BIT_MEM is asserted.
    - If mem_wait: counter++ and stay. When the counter reaches MEM_TIMEOUT-1 with mem_wait still high (MEM_TIMEOUT>0), go to TRAP instead.
    - If !mem_wait: go to MEM_DELAY, counter cleared.
    - The counter is cleared on every MEM entry.
  - MEM_DELAY -> REG_WR.
  - REG_WR (BIT_REG_WR always asserted), priority order:
    - should_branch: pc_op=SET, go to PC_DELAY.
    - Else irq_pend: pc_op=NOP, go to IRQ_SAVE.
    - Else halt_req: pc_op=NOP, go to HALT.
    - Else: BIT_FETCH also asserted, pc_op=INC, go to DECODE (overlapped fetch).
  - PC_DELAY: BIT_PC_DELAY; go to IRQ_SAVE if irq_pend, else to FETCH.
  - TRAP: bus_err=1 for one cycle; irq_id<=IRQ_LINES; go to IRQ_SAVE. The trap is taken regardless of irq_en.
  - IRQ_SAVE:
    - BIT_IRQ_SAVE is asserted; the datapath pushes PC.
    - If entered from TRAP, irq_ack=0 and irq_id is kept.
    - Otherwise irq_id<=index of the lowest set irq bit, and irq_ack is one-hot for that line.
    - Go to IRQ_VEC.
    - If irq drops before IRQ_SAVE is entered, go to IRQ_VEC with the last latched id (spurious entry is tolerated; software handles it).
  - IRQ_VEC: pc_op=VEC (PC <- vector table[irq_id]); go to FETCH.
  - HALT:
    - halted=1.
    - Leave for IRQ_SAVE if irq_pend (wake), else for FETCH when halt_req=0.
  - Illegal encodings -> FETCH.
- en=0: state, counter and irq_id hold. Combinational outputs still reflect the current state. irq_ack and bus_err are qualified with en so each pulses exactly once.
- mem_wait dropping on the exact timeout cycle: !mem_wait wins, go to MEM_DELAY.
- Interrupts are taken only at an instruction boundary (REG_WR or PC_DELAY); never mid-MEM.

Decomposition:
- cpu_constants.vh gains the following:
  - CTRL_W=8 and bit indices BIT_FETCH..BIT_PC_DELAY unchanged, plus BIT_IRQ_SAVE=7.
  - pc_op widened to 3 bits: PC_NOP=0, PC_INC=1, PC_SET=2, PC_RESET=3, PC_VEC=4.
  - State localparams stay local.
- One sub-module: irq_prio_enc (parametrised lowest-index priority encoder, producing a valid flag, id and one-hot output).

Test Plan:
- Reset then en=1, no memory op, imm=0, no branch: states RST,FETCH,DECODE,REG_READ,ALU,REG_WR,DECODE; pc_op sequence 3,1,0,0,0,1.
- ifetch_wait=1 for 3 cycles in FETCH: control_o=BIT_FETCH held 4 cycles; pc_op=INC only on the 4th.
- en_mem=1, mem_wait=1 for 5 cycles, MEM_TIMEOUT=16: MEM for 6 cycles, then MEM_DELAY, REG_WR; bus_err stays 0.
- mem_wait stuck high, MEM_TIMEOUT=16: TRAP after 16 MEM cycles, bus_err single pulse, irq_id=4, irq_ack=0, then IRQ_VEC with pc_op=4.
- irq=4'b0110, irq_en=1 at REG_WR with no branch: IRQ_SAVE with irq_ack=4'b0010 and irq_id=1, then IRQ_VEC, then FETCH; with irq_en=0 the sequence is the normal DECODE.
- halt_req=1 at REG_WR: HALT with halted=1; deassert -> FETCH. A second run with irq[0] raised while halted: wake to IRQ_SAVE with irq_id=0.
